// File: rtl/iiitb_lifo_param.sv
// ============================================================================
// Module      : iiitb_lifo_param
// Description : Parametrised synchronous LIFO stack with replace-top, peek,
//               occupancy count and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iiitb_lifo_param #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              rd_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVF,
  output logic              UNF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;
  logic [DATA_W-1:0] r_dout;
  logic              r_rd_valid;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_top_data;
  logic              w_push_only;
  logic              w_pop_only;
  logic              w_both;
  logic              w_mem_we;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              w_rd_valid_nxt;
  logic              w_ovf_err;
  logic              w_unf_err;

  // Index values are only meaningful when the guards below make them in range.
  assign w_top_idx   = PTR_W'(r_count - CNT_W'(1));
  assign w_top_data  = r_mem[w_top_idx];
  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_both      = push & pop;
  assign w_ovf_err   = w_push_only & r_full;
  assign w_unf_err   = w_pop_only & r_empty;

  always_comb begin
    w_count_nxt    = r_count;
    w_dout_nxt     = r_dout;
    w_rd_valid_nxt = 1'b0;
    w_mem_we       = 1'b0;
    w_wr_idx       = PTR_W'(r_count);
    if (w_push_only && !r_full) begin
      w_mem_we    = 1'b1;
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop_only && !r_empty) begin
      w_dout_nxt     = w_top_data;
      w_rd_valid_nxt = 1'b1;
      w_count_nxt    = r_count - CNT_W'(1);
    end else if (w_both) begin
      w_rd_valid_nxt = 1'b1;
      if (r_empty) begin
        w_dout_nxt = dataIn;
      end else begin
        w_dout_nxt = w_top_data;
        w_mem_we   = 1'b1;
        w_wr_idx   = w_top_idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (!EN) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == c_DEPTH);
      r_dout     <= w_dout_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      // A fresh error outranks a simultaneous clear.
      r_ovf      <= w_ovf_err | (r_ovf & ~clr_err);
      r_unf      <= w_unf_err | (r_unf & ~clr_err);
    end
  end

  // Storage is left unreset; the top output is masked while empty.
  always_ff @(posedge Clk) begin
    if (!Rst && EN && w_mem_we) begin
      r_mem[w_wr_idx] <= dataIn;
    end
  end

  assign dataOut  = r_dout;
  assign rd_valid = r_rd_valid;
  assign top      = r_empty ? '0 : w_top_data;
  assign count    = r_count;
  assign EMPTY    = r_empty;
  assign FULL     = r_full;
  assign OVF      = r_ovf;
  assign UNF      = r_unf;

endmodule

`default_nettype wire
